// File: rtl/vscale_md_issue_pkg.sv
// Shared encodings for the RV32M issue/writeback wrapper and its decoder.
package vscale_md_issue_pkg;

  localparam int XPR_LEN          = 32;
  localparam int MD_OP_WIDTH      = 2;
  localparam int MD_OUT_SEL_WIDTH = 2;

  typedef enum logic [MD_OP_WIDTH-1:0] {
    MD_OP_MUL = 2'd0,
    MD_OP_DIV = 2'd1,
    MD_OP_REM = 2'd2
  } md_op_e;

  typedef enum logic [MD_OUT_SEL_WIDTH-1:0] {
    MD_OUT_LO  = 2'd0,
    MD_OUT_HI  = 2'd1,
    MD_OUT_REM = 2'd2
  } md_out_sel_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4
  } state_e;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/vscale_md_decode.sv
// Combinational RV32M funct3 decoder producing mul/div unit controls.
module vscale_md_decode
  import vscale_md_issue_pkg::*;
(
  input  logic [2:0]  funct3,
  output md_op_e      op,
  output md_out_sel_e out_sel,
  output logic        in_1_signed,
  output logic        in_2_signed
);

  always_comb begin
    op          = MD_OP_MUL;
    out_sel     = MD_OUT_LO;
    in_1_signed = 1'b1;
    in_2_signed = 1'b1;
    case (funct3)
      F3_MUL:    ;
      F3_MULH:   out_sel = MD_OUT_HI;
      F3_MULHSU: begin
        out_sel     = MD_OUT_HI;
        in_2_signed = 1'b0;
      end
      F3_MULHU:  begin
        out_sel     = MD_OUT_HI;
        in_1_signed = 1'b0;
        in_2_signed = 1'b0;
      end
      F3_DIV:    op = MD_OP_DIV;
      F3_DIVU:   begin
        op          = MD_OP_DIV;
        in_1_signed = 1'b0;
        in_2_signed = 1'b0;
      end
      F3_REM:    begin
        op      = MD_OP_REM;
        out_sel = MD_OUT_REM;
      end
      F3_REMU:   begin
        op          = MD_OP_REM;
        out_sel     = MD_OUT_REM;
        in_1_signed = 1'b0;
        in_2_signed = 1'b0;
      end
      default:   ;
    endcase
  end

endmodule

// File: rtl/vscale_md_issue.sv
// Issue/writeback wrapper around the RV32M mul/div unit: one instruction in
// flight, divide-by-zero bypass, flush with drain of an unabortable response.
module vscale_md_issue #(
  parameter int XPR_LEN        = vscale_md_issue_pkg::XPR_LEN,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [2:0]                                     in_funct3,
  input  logic [XPR_LEN-1:0]                             in_rs1,
  input  logic [XPR_LEN-1:0]                             in_rs2,
  input  logic [REG_ADDR_WIDTH-1:0]                      in_rd,
  input  logic                                           flush,
  output logic                                           md_req_valid,
  input  logic                                           md_req_ready,
  output logic [vscale_md_issue_pkg::MD_OP_WIDTH-1:0]      md_req_op,
  output logic [vscale_md_issue_pkg::MD_OUT_SEL_WIDTH-1:0] md_req_out_sel,
  output logic                                           md_req_in_1_signed,
  output logic                                           md_req_in_2_signed,
  output logic [XPR_LEN-1:0]                             md_req_in_1,
  output logic [XPR_LEN-1:0]                             md_req_in_2,
  input  logic                                           md_resp_valid,
  input  logic [XPR_LEN-1:0]                             md_resp_result,
  output logic                                           wb_valid,
  input  logic                                           wb_ready,
  output logic [REG_ADDR_WIDTH-1:0]                      wb_rd,
  output logic [XPR_LEN-1:0]                             wb_data
);

  vscale_md_issue_pkg::state_e      state;
  vscale_md_issue_pkg::md_op_e      dec_op, op_q;
  vscale_md_issue_pkg::md_out_sel_e dec_out_sel, out_sel_q;
  logic                             dec_s1, dec_s2, s1_q, s2_q;
  logic [XPR_LEN-1:0]               in1_q, in2_q, data_q;
  logic [REG_ADDR_WIDTH-1:0]        rd_q;
  logic                             accept, div_zero;

  vscale_md_decode u_decode (
    .funct3      (in_funct3),
    .op          (dec_op),
    .out_sel     (dec_out_sel),
    .in_1_signed (dec_s1),
    .in_2_signed (dec_s2)
  );

  assign in_ready     = (state == vscale_md_issue_pkg::S_IDLE) && !flush;
  assign md_req_valid = (state == vscale_md_issue_pkg::S_ISSUE) && !flush;
  assign wb_valid     = (state == vscale_md_issue_pkg::S_HOLD);
  assign accept       = in_valid && in_ready;
  assign div_zero     = in_funct3[2] && (in_rs2 == '0);

  assign md_req_op          = op_q;
  assign md_req_out_sel     = out_sel_q;
  assign md_req_in_1_signed = s1_q;
  assign md_req_in_2_signed = s2_q;
  assign md_req_in_1        = in1_q;
  assign md_req_in_2        = in2_q;
  assign wb_rd              = rd_q;
  assign wb_data            = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= vscale_md_issue_pkg::S_IDLE;
      op_q      <= vscale_md_issue_pkg::MD_OP_MUL;
      out_sel_q <= vscale_md_issue_pkg::MD_OUT_LO;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      in1_q     <= '0;
      in2_q     <= '0;
      rd_q      <= '0;
      data_q    <= '0;
    end else begin
      case (state)
        vscale_md_issue_pkg::S_IDLE: begin
          if (accept) begin
            op_q      <= dec_op;
            out_sel_q <= dec_out_sel;
            s1_q      <= dec_s1;
            s2_q      <= dec_s2;
            in1_q     <= in_rs1;
            in2_q     <= in_rs2;
            rd_q      <= in_rd;
            // Divide by zero never reaches the unit: RISC-V fixes the result.
            if (div_zero) begin
              data_q <= (dec_op == vscale_md_issue_pkg::MD_OP_DIV) ? '1 : in_rs1;
              state  <= vscale_md_issue_pkg::S_HOLD;
            end else begin
              state  <= vscale_md_issue_pkg::S_ISSUE;
            end
          end
        end
        vscale_md_issue_pkg::S_ISSUE: begin
          if (flush)             state <= vscale_md_issue_pkg::S_IDLE;
          else if (md_req_ready) state <= vscale_md_issue_pkg::S_WAIT;
        end
        vscale_md_issue_pkg::S_WAIT: begin
          // A strobe coinciding with flush is consumed here, so no drain is needed.
          if (flush) begin
            state <= md_resp_valid ? vscale_md_issue_pkg::S_IDLE
                                   : vscale_md_issue_pkg::S_DRAIN;
          end else if (md_resp_valid) begin
            data_q <= md_resp_result;
            state  <= vscale_md_issue_pkg::S_HOLD;
          end
        end
        vscale_md_issue_pkg::S_DRAIN: begin
          if (md_resp_valid) state <= vscale_md_issue_pkg::S_IDLE;
        end
        vscale_md_issue_pkg::S_HOLD: begin
          if (flush || wb_ready) state <= vscale_md_issue_pkg::S_IDLE;
        end
        default: state <= vscale_md_issue_pkg::S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vscale_md_issue.sv
// Bench for vscale_md_issue with a behavioural 34-cycle mul/div unit model.
module tb_vscale_md_issue;

  logic        clk = 1'b0;
  logic        reset, in_valid, flush, wb_ready;
  logic        in_ready, md_req_valid, md_req_in_1_signed, md_req_in_2_signed, wb_valid;
  logic        md_req_ready;
  logic        md_resp_valid = 1'b0;
  logic [31:0] md_resp_result = '0;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1, in_rs2, md_req_in_1, md_req_in_2, wb_data;
  logic [4:0]  in_rd, wb_rd;
  logic [1:0]  md_req_op, md_req_out_sel;

  int cyc = 0, checks = 0, errors = 0, req_cnt = 0, req_cyc = 0;
  int unit_cnt = 0;
  logic unit_busy = 1'b0;
  logic [36:0] exp_q[$];

  vscale_md_issue #(.XPR_LEN(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .flush(flush), .md_req_valid(md_req_valid), .md_req_ready(md_req_ready),
    .md_req_op(md_req_op), .md_req_out_sel(md_req_out_sel),
    .md_req_in_1_signed(md_req_in_1_signed), .md_req_in_2_signed(md_req_in_2_signed),
    .md_req_in_1(md_req_in_1), .md_req_in_2(md_req_in_2),
    .md_resp_valid(md_resp_valid), .md_resp_result(md_resp_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] unit_calc(input logic [1:0] op, input logic [1:0] sel,
                                            input logic sa, input logic sb,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0] a64, b64, p;
    a64 = sa ? {{32{a[31]}}, a} : {32'b0, a};
    b64 = sb ? {{32{b[31]}}, b} : {32'b0, b};
    p   = a64 * b64;
    case (op)
      2'd0:    return (sel == 2'd1) ? p[63:32] : p[31:0];
      2'd1:    return sa ? 32'($signed(a) / $signed(b)) : a / b;
      default: return sa ? 32'($signed(a) % $signed(b)) : a % b;
    endcase
  endfunction

  // Unit model: request accepted at the edge ending cycle N+1, strobe in cycle N+35.
  always @(posedge clk) begin
    if (reset) begin
      unit_busy     <= 1'b0;
      unit_cnt      <= 0;
      md_resp_valid <= 1'b0;
    end else begin
      md_resp_valid <= 1'b0;
      if (!unit_busy && md_req_valid && md_req_ready) begin
        unit_busy      <= 1'b1;
        unit_cnt       <= 0;
        md_resp_result <= unit_calc(md_req_op, md_req_out_sel, md_req_in_1_signed,
                                    md_req_in_2_signed, md_req_in_1, md_req_in_2);
        req_cnt        <= req_cnt + 1;
        req_cyc        <= cyc;
      end else if (unit_busy) begin
        unit_cnt <= unit_cnt + 1;
        if (unit_cnt == 32) begin
          md_resp_valid <= 1'b1;
          unit_busy     <= 1'b0;
        end
      end
    end
  end
  assign md_req_ready = !unit_busy && !md_resp_valid;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] expd, input bit push,
                       input string tag, output int acc);
    in_valid = 1'b1; in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_rd = rd;
    @(negedge clk);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    acc = cyc;
    if (push) exp_q.push_back({rd, expd});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_wb(input int acc, input int lat, input int stall, input string tag,
                         output int m);
    int n;
    logic [36:0] e;
    n = 0;
    @(negedge clk);
    while (!wb_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_wb_valid"}, 64'(wb_valid), 64'd1);
    check({tag, "_latency"}, 64'(cyc - acc), 64'(lat));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, "_wb_rd"}, 64'(wb_rd), 64'(e[36:32]));
    check({tag, "_wb_data"}, 64'(wb_data), 64'(e[31:0]));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, 64'(wb_valid), 64'd1);
      check({tag, "_stall_data"}, 64'(wb_data), 64'(e[31:0]));
      check({tag, "_stall_rd"}, 64'(wb_rd), 64'(e[36:32]));
      check({tag, "_stall_in_ready"}, 64'(in_ready), 64'd0);
    end
    wb_ready = 1'b1;
    m = cyc;
    @(posedge clk); #1;
    wb_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_md_req_valid"}, 64'(md_req_valid), 64'd0);
    check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    check({tag, "_req_fields"}, {md_req_op, md_req_out_sel, md_req_in_1_signed,
          md_req_in_2_signed, md_req_in_1, md_req_in_2}, 64'd0);
    check({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
    check({tag, "_wb_data"}, 64'(wb_data), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int acc, acc2, m, reqs;
    logic saw, rdy35;
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_ready = 1'b0;
    in_funct3 = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;

    issue(3'b001, 32'hFFFF_FFFF, 32'd2, 5'd5, 32'hFFFF_FFFF, 1'b1, "mulh", acc);
    wait_wb(acc, 36, 0, "mulh", m);
    check("mulh_req_cycle", 64'(req_cyc - acc), 64'd1);

    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 1'b1, "div", acc);
    wait_wb(acc, 36, 0, "div", m);
    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 1'b1, "rem", acc);
    wait_wb(acc, 36, 0, "rem", m);

    reqs = req_cnt;
    issue(3'b100, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1'b1, "div0", acc);
    wait_wb(acc, 1, 0, "div0", m);
    issue(3'b111, 32'd5, 32'd0, 5'd9, 32'd5, 1'b1, "remu0", acc);
    wait_wb(acc, 1, 0, "remu0", m);
    check("div0_no_request", 64'(req_cnt), 64'(reqs));

    issue(3'b000, 32'd3, 32'd4, 5'd10, 32'd12, 1'b0, "flush", acc);
    while (cyc != acc + 10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    saw = 1'b0; rdy35 = 1'bx;
    for (int k = acc + 11; k <= acc + 35; k++) begin
      @(negedge clk);
      saw = saw | wb_valid;
      if (k == acc + 35) rdy35 = in_ready;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("flush_no_wb", 64'(saw), 64'd0);
    check("flush_drain_busy", 64'(rdy35), 64'd0);
    check("flush_in_ready_n36", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    issue(3'b000, 32'd7, 32'd6, 5'd11, 32'd42, 1'b1, "stall", acc);
    wait_wb(acc, 36, 5, "stall", m);
    issue(3'b101, 32'd100, 32'd7, 5'd12, 32'd14, 1'b1, "b2b", acc2);
    check("b2b_accept_cycle", 64'(acc2 - m), 64'd1);
    wait_wb(acc2, 36, 0, "b2b", m);

    issue(3'b000, 32'd3, 32'd3, 5'd13, 32'd9, 1'b0, "rstwait", acc);
    while (cyc != acc + 5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd14, 32'hFFFF_FFFE, 1'b1, "mulhu", acc);
    wait_wb(acc, 36, 0, "mulhu", m);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vscale_md_issue.md
# vscale_md_issue

Issue/writeback wrapper sitting directly upstream and downstream of the RV32M multiply/divide unit. It accepts one decoded M-extension instruction (funct3, operands, destination register) from the execute stage and translates funct3 into the unit's op/out_sel/signedness controls. It drives the unit's request handshake and captures the unit's single-cycle response. It then holds the result under a valid/ready writeback handshake. It also short-circuits divide-by-zero to the RISC-V-mandated results and supports pipeline flush.

## Interface
- XPR_LEN, 32, operand/result width
- REG_ADDR_WIDTH, 5, destination register index width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- in_funct3  in  3  RV32M funct3
- in_rs1, in_rs2  in  XPR_LEN  operands
- in_rd  in  REG_ADDR_WIDTH  destination tag
- flush  in  1  kill in-flight instruction
- md_req_valid  out  1  request to mul/div unit
- md_req_ready  in  1  unit idle
- md_req_op  out  MD_OP_WIDTH  unit opcode
- md_req_out_sel  out  MD_OUT_SEL_WIDTH  unit output select
- md_req_in_1_signed, md_req_in_2_signed  out  1  operand signedness
- md_req_in_1, md_req_in_2  out  XPR_LEN  operands
- md_resp_valid  in  1  one-cycle result strobe
- md_resp_result  in  XPR_LEN  result
- wb_valid  out  1  result available
- wb_ready  in  1  writeback accepts
- wb_rd  out  REG_ADDR_WIDTH  destination tag
- wb_data  out  XPR_LEN  result

## Operation
- Decode (funct3 → op, out_sel, s1, s2): 000 MUL,LO,1,1; 001 MUL,HI,1,1; 010 MUL,HI,1,0; 011 MUL,HI,0,0; 100 DIV,LO,1,1; 101 DIV,LO,0,0; 110 REM,REM,1,1; 111 REM,REM,0,0.
- Encodings: MD_OP_MUL=0, DIV=1, REM=2; MD_OUT_LO=0, HI=1, REM=2.
- States: IDLE, ISSUE, WAIT, DRAIN, HOLD.
- IDLE: in_ready = !flush. On accept, register decoded controls, operands and rd.
  - If funct3[2]=1 and in_rs2==0, go to HOLD directly. Data is all-ones for DIV/DIVU and in_rs1 for REM/REMU.
  - Otherwise go to ISSUE.
- ISSUE: md_req_valid = !flush. Request fields come from registers only.
  - flush → IDLE, no request issued.
  - md_req_valid & md_req_ready → WAIT.
- WAIT: on md_resp_valid, capture md_resp_result → HOLD. flush → DRAIN; if md_resp_valid coincides with flush, discard the result and go to IDLE.
- DRAIN: on md_resp_valid, discard → IDLE. The unit has no abort, so its result must be consumed.
- HOLD: wb_valid=1; wb_rd/wb_data stable until wb_ready. wb_ready → IDLE. flush → IDLE, no writeback.
- md_resp_valid is a one-cycle strobe with no backpressure. It must be captured in the cycle it is seen.
- md_resp_valid outside WAIT/DRAIN is ignored.
- Overflow (0x80000000 / 0xFFFFFFFF) is not special-cased; the unit returns 0x80000000 / rem 0.

## Timing
- Reset: state IDLE.
- Reset values: in_ready=1, md_req_valid=0, wb_valid=0. md_req_* data, wb_rd and wb_data all =0.
- Reset mid-operation aborts to IDLE. The unit shares reset, so no drain is needed.
- Accept at cycle N:
  - md_req_valid at N+1. The unit is idle, so the handshake completes at N+1.
  - Unit strobe at N+35 (1 accept + 32 compute + setup + done).
  - wb_valid at N+36.
- Divide-by-zero bypass: wb_valid at N+1.
- One instruction in flight; in_ready=0 in every state except IDLE.
- Back-to-back: wb_ready at cycle M gives in_ready at M+1.
- Flush has priority over every other event in the same cycle.

## Structure
- Shared package/header:
  - MD_OP_* and MD_OUT_* encodings and widths, XPR_LEN.
  - State encoding (3 bits).
  - RV32M funct3 constants.
- Sub-module vscale_md_decode: a combinational funct3 → controls decoder, reused by the control unit.
- The FSM and registers live in the top module.

## Test plan
- MULH: rs1=0xFFFFFFFF, rs2=0x00000002 → wb_data=0xFFFFFFFF, wb_valid at N+36, wb_rd echoed.
- DIV: rs1=0xFFFFFFF9 (-7), rs2=2 → wb_data=0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF.
- Divide-by-zero: DIV rs1=5, rs2=0 → 0xFFFFFFFF at N+1. REMU with the same operands → 5. md_req_valid never asserted.
- Flush in WAIT at N+10: no wb_valid; the strobe at N+35 is discarded; in_ready at N+36.
- Writeback stall: wb_ready low for 5 cycles in HOLD → wb_data/wb_rd stable, in_ready=0 throughout. A second request is accepted the cycle after wb_ready.
- Reset asserted during WAIT → next cycle all outputs at reset values. A fresh MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
